seg7_time_scan: RTL

- Downstream display stage for the HH:MM:SS time counter.
- Consumes the counter's BCD digit outputs (hour, minute, second) and time-multiplexes them onto an 8-digit common-anode 7-segment display as "HH-MM-SS".
- Includes a scan prescaler, a digit-index counter and a per-frame input snapshot, so a digit never tears mid-frame.
- All display outputs are registered.

---
 rtl/seg7_time_scan_if.sv | 20 ++
 rtl/seg7_time_scan.sv | 109 ++++++++++
 2 files changed

// File: rtl/seg7_time_scan_if.sv
// Display-stage bundle: BCD time digits and enable in, anode/segment drive and frame pulse out.
interface seg7_time_scan_if;
  logic            disp_en;
  logic [1:0][3:0] hour;
  logic [1:0][3:0] minute;
  logic [1:0][3:0] second;
  logic [7:0]      an;
  logic [6:0]      seg;
  logic            frame_start;

  modport master (
    output disp_en, hour, minute, second,
    input  an, seg, frame_start
  );

  modport slave (
    input  disp_en, hour, minute, second,
    output an, seg, frame_start
  );
endinterface

// File: rtl/seg7_time_scan.sv
// HH-MM-SS scan driver for an 8-digit common-anode display; an/seg follow idx by 1 cycle, no backpressure.
// Optional SEG7_LEAD_ZERO_BLANK_EN blanks a zero hour-tens digit in slot 7.
module seg7_time_scan #(
  parameter int SCAN_DIV = 100_000
) (
  input logic            clk,
  input logic            reset,
  seg7_time_scan_if.slave bus
);

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_DASH  = 7'b0111111;
  localparam logic [6:0]     SEG_BLANK = 7'h7F;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0][3:0] hour_q, hour_d;
  logic [1:0][3:0] minute_q, minute_d;
  logic [1:0][3:0] second_q, second_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            frame_start_q, frame_start_d;
  logic            tick;
  logic            wrap;
  logic [3:0]      digit;
  logic            is_dash;
  logic            blank_lead;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    tick          = (cnt_q == CNT_MAX);
    wrap          = tick && (idx_q == 3'd7);
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = tick ? idx_q + 3'd1 : idx_q;
    frame_start_d = wrap;

    // Inputs are only sampled at the frame wrap so a frame never mixes two times.
    hour_d   = wrap ? bus.hour   : hour_q;
    minute_d = wrap ? bus.minute : minute_q;
    second_d = wrap ? bus.second : second_q;

    digit      = '0;
    is_dash    = 1'b0;
    blank_lead = 1'b0;
    case (idx_q)
      3'd0:    digit = second_q[0];
      3'd1:    digit = second_q[1];
      3'd2:    is_dash = 1'b1;
      3'd3:    digit = minute_q[0];
      3'd4:    digit = minute_q[1];
      3'd5:    is_dash = 1'b1;
      3'd6:    digit = hour_q[0];
      default: digit = hour_q[1];
    endcase
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    blank_lead = (idx_q == 3'd7) && (hour_q[1] == 4'd0);
`endif

    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    if (bus.disp_en) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = is_dash ? SEG_DASH : (blank_lead ? SEG_BLANK : bcd_to_seg(digit));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      hour_q        <= '0;
      minute_q      <= '0;
      second_q      <= '0;
      an_q          <= 8'hFF;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      hour_q        <= hour_d;
      minute_q      <= minute_d;
      second_q      <= second_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;

endmodule
